// File: rtl/analog_probe_sequencer_if.sv
// Request/response bundle between the analog probe sequencer and its controller/probe side.
// The slave modport is the sequencer; master is the controller that starts runs and supplies probe results.
interface analog_probe_sequencer_if;
    logic        start;
    logic [2:0]  channel_mask;
    logic        probe_voltage_toggle;
    logic        probe_current_toggle;
    logic        probe_power_toggle;
    real         voltage_in;
    real         current_in;
    real         power_in;
    logic        busy;
    logic        done;
    real         voltage_avg;
    real         current_avg;
    real         power_avg;
    logic [15:0] round_count;

    modport master (
        output start, channel_mask, voltage_in, current_in, power_in,
        input  probe_voltage_toggle, probe_current_toggle, probe_power_toggle,
        input  busy, done, voltage_avg, current_avg, power_avg, round_count
    );

    modport slave (
        input  start, channel_mask, voltage_in, current_in, power_in,
        output probe_voltage_toggle, probe_current_toggle, probe_power_toggle,
        output busy, done, voltage_avg, current_avg, power_avg, round_count
    );
endinterface

// File: rtl/analog_probe_sequencer.sv
// Toggle-protocol initiator: requests voltage/current/power probes in rotation,
// captures settled results, and reports per-channel averages over NUM_SAMPLES rounds.
module analog_probe_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_SAMPLES   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    analog_probe_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        FINISH  = 3'd4
    } state_t;

    localparam logic [7:0]  SETTLE_LOAD   = 8'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [15:0] NUM_SAMPLES_W = 16'(NUM_SAMPLES);
    localparam real         NUM_SAMPLES_R = real'(NUM_SAMPLES);

    state_t      state_r;
    logic [2:0]  mask_r;
    logic [1:0]  sel_r;
    logic [7:0]  settle_cnt_r;
    logic [15:0] round_count_r;
    logic        busy_r;
    logic        done_r;
    logic        v_tog_r;
    logic        i_tog_r;
    logic        p_tog_r;
    real         v_acc_r;
    real         i_acc_r;
    real         p_acc_r;
    real         v_avg_r;
    real         i_avg_r;
    real         p_avg_r;

    // Lowest enabled channel in voltage, current, power order.
    function automatic logic [1:0] first_chan(input logic [2:0] mask);
        logic [1:0] idx;
        if (mask[0]) begin
            idx = 2'd0;
        end else if (mask[1]) begin
            idx = 2'd1;
        end else if (mask[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    // {found, index} of the next enabled channel after cur within the same round.
    function automatic logic [2:0] next_chan(input logic [2:0] mask, input logic [1:0] cur);
        logic [2:0] res;
        res = 3'b000;
        case (cur)
            2'd0: begin
                if (mask[1]) begin
                    res = {1'b1, 2'd1};
                end else if (mask[2]) begin
                    res = {1'b1, 2'd2};
                end else begin
                    res = 3'b000;
                end
            end
            2'd1: begin
                if (mask[2]) begin
                    res = {1'b1, 2'd2};
                end else begin
                    res = 3'b000;
                end
            end
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    assign bus.probe_voltage_toggle = v_tog_r;
    assign bus.probe_current_toggle = i_tog_r;
    assign bus.probe_power_toggle   = p_tog_r;
    assign bus.busy                 = busy_r;
    assign bus.done                 = done_r;
    assign bus.voltage_avg          = v_avg_r;
    assign bus.current_avg          = i_avg_r;
    assign bus.power_avg            = p_avg_r;
    assign bus.round_count          = round_count_r;

    // Sequencer FSM with all outputs, accumulators and averages held in registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            mask_r        <= 3'b000;
            sel_r         <= 2'd0;
            settle_cnt_r  <= 8'd0;
            round_count_r <= 16'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            v_tog_r       <= 1'b0;
            i_tog_r       <= 1'b0;
            p_tog_r       <= 1'b0;
            v_acc_r       <= 0.0;
            i_acc_r       <= 0.0;
            p_acc_r       <= 0.0;
            v_avg_r       <= 0.0;
            i_avg_r       <= 0.0;
            p_avg_r       <= 0.0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    // The done cycle is itself spent in IDLE; a start seen there is dropped.
                    if (bus.start && !done_r) begin
                        mask_r        <= bus.channel_mask;
                        v_acc_r       <= 0.0;
                        i_acc_r       <= 0.0;
                        p_acc_r       <= 0.0;
                        round_count_r <= 16'd0;
                        busy_r        <= 1'b1;
                        if (bus.channel_mask == 3'b000) begin
                            state_r <= FINISH;
                        end else begin
                            sel_r   <= first_chan(bus.channel_mask);
                            state_r <= REQ;
                        end
                    end
                end
                REQ: begin
                    case (sel_r)
                        2'd0:    v_tog_r <= ~v_tog_r;
                        2'd1:    i_tog_r <= ~i_tog_r;
                        2'd2:    p_tog_r <= ~p_tog_r;
                        default: v_tog_r <= v_tog_r;
                    endcase
                    settle_cnt_r <= SETTLE_LOAD;
                    if (SETTLE_CYCLES == 0) begin
                        state_r <= CAPTURE;
                    end else begin
                        state_r <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_r == 8'd0) begin
                        state_r <= CAPTURE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 8'd1;
                    end
                end
                CAPTURE: begin
                    case (sel_r)
                        2'd0:    v_acc_r <= v_acc_r + bus.voltage_in;
                        2'd1:    i_acc_r <= i_acc_r + bus.current_in;
                        2'd2:    p_acc_r <= p_acc_r + bus.power_in;
                        default: v_acc_r <= v_acc_r;
                    endcase
                    if (next_chan(mask_r, sel_r) != 3'b000) begin
                        sel_r   <= next_chan(mask_r, sel_r) & 3'b011;
                        state_r <= REQ;
                    end else begin
                        round_count_r <= round_count_r + 16'd1;
                        if ((round_count_r + 16'd1) == NUM_SAMPLES_W) begin
                            state_r <= FINISH;
                        end else begin
                            sel_r   <= first_chan(mask_r);
                            state_r <= REQ;
                        end
                    end
                end
                FINISH: begin
                    v_avg_r <= mask_r[0] ? (v_acc_r / NUM_SAMPLES_R) : 0.0;
                    i_avg_r <= mask_r[1] ? (i_acc_r / NUM_SAMPLES_R) : 0.0;
                    p_avg_r <= mask_r[2] ? (p_acc_r / NUM_SAMPLES_R) : 0.0;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_analog_probe_sequencer.sv
// Self-checking bench for analog_probe_sequencer: directed and randomized runs checked
// against an edge-indexed model of when each conversion flips its toggle and captures.
module tb_analog_probe_sequencer;
    localparam int S = 2;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks_total  = 0;
    int   checks_passed = 0;
    real  vv [0:255];
    real  iv [0:255];
    real  pv [0:255];

    always #5 clk = ~clk;

    analog_probe_sequencer_if bus_if ();

    analog_probe_sequencer #(.SETTLE_CYCLES(S), .NUM_SAMPLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    task automatic check_val(input string tag, input real got, input real exp);
        checks_total++;
        if ((got == exp) || ((got - exp) < 1.0e-9 && (exp - got) < 1.0e-9)) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %g expected %g", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string pre);
        check_val({pre, "_vtog"},  real'(bus_if.probe_voltage_toggle), 0.0);
        check_val({pre, "_itog"},  real'(bus_if.probe_current_toggle), 0.0);
        check_val({pre, "_ptog"},  real'(bus_if.probe_power_toggle), 0.0);
        check_val({pre, "_busy"},  real'(bus_if.busy), 0.0);
        check_val({pre, "_done"},  real'(bus_if.done), 0.0);
        check_val({pre, "_vavg"},  bus_if.voltage_avg, 0.0);
        check_val({pre, "_iavg"},  bus_if.current_avg, 0.0);
        check_val({pre, "_pavg"},  bus_if.power_avg, 0.0);
        check_val({pre, "_round"}, real'(bus_if.round_count), 0.0);
    endtask

    function automatic real rnd_real();
        return real'($urandom_range(0, 10000)) / 1000.0 - 5.0;
    endfunction

    // mode 0: held constants, 1: voltage stepped per conversion slot, 2: mid-run start/mask
    // disturbance, 3: start during the done cycle, 4: fully random inputs.
    task automatic do_run(input logic [2:0] mask, input int mode, input int rst_at);
        int   en [3];
        int   k_en;
        int   total;
        int   exp_done;
        int   done_k;
        int   done_cnt;
        int   tog_err;
        int   busy_err;
        int   exp_round;
        logic [2:0] prev_tog;
        logic [2:0] cur_tog;
        logic [2:0] exp_flip;
        real  sum [3];
        real  exp_avg [3];
        k_en = 0;
        for (int c = 0; c < 3; c++) begin
            en[c] = 0;
            sum[c] = 0.0;
            if (mask[c]) begin
                en[k_en] = c;
                k_en++;
            end
        end
        total    = k_en * N * (S + 2);
        exp_done = total + 1;
        done_k   = 0;
        done_cnt = 0;
        tog_err  = 0;
        busy_err = 0;

        @(negedge clk);
        bus_if.start        = 1'b1;
        bus_if.channel_mask = mask;
        prev_tog = {bus_if.probe_power_toggle, bus_if.probe_current_toggle, bus_if.probe_voltage_toggle};
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;

        for (int k = 1; k <= exp_done + 6; k++) begin
            if (mode == 0) begin
                vv[k] = 1.2;
                iv[k] = 0.05;
                pv[k] = 0.06;
            end else if (mode == 1) begin
                vv[k] = real'((k - 1) / (S + 2) + 1);
                iv[k] = rnd_real();
                pv[k] = rnd_real();
            end else begin
                vv[k] = rnd_real();
                iv[k] = rnd_real();
                pv[k] = rnd_real();
            end
            bus_if.voltage_in = vv[k];
            bus_if.current_in = iv[k];
            bus_if.power_in   = pv[k];
            if (mode == 2 && k == 5)  bus_if.start = 1'b1;
            if (mode == 2 && k == 6)  bus_if.start = 1'b0;
            if (mode == 2 && k == 10) bus_if.channel_mask = 3'b010;
            if (mode == 3 && k == exp_done + 1) bus_if.start = 1'b1;
            if (mode == 3 && k == exp_done + 2) bus_if.start = 1'b0;
            if (k == rst_at) rst = 1'b1;
            @(posedge clk);
            #1;
            if (k == rst_at) begin
                rst = 1'b0;
                check_idle_zero("midrun_rst");
                return;
            end
            cur_tog  = {bus_if.probe_power_toggle, bus_if.probe_current_toggle, bus_if.probe_voltage_toggle};
            exp_flip = 3'b000;
            if ((k - 1) < total && ((k - 1) % (S + 2)) == 0)
                exp_flip[en[((k - 1) / (S + 2)) % k_en]] = 1'b1;
            if ((cur_tog ^ prev_tog) != exp_flip) tog_err++;
            prev_tog = cur_tog;
            if (bus_if.busy != (k < exp_done)) busy_err++;
            if (bus_if.done) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
            end
        end

        for (int j = 0; j < k_en * N; j++) begin
            int c;
            int e;
            c = en[j % k_en];
            e = (j + 1) * (S + 2);
            if (c == 0)      sum[0] += vv[e];
            else if (c == 1) sum[1] += iv[e];
            else             sum[2] += pv[e];
        end
        for (int c = 0; c < 3; c++)
            exp_avg[c] = mask[c] ? (sum[c] / real'(N)) : 0.0;
        exp_round = (mask == 3'b000) ? 0 : N;

        check_val("done_edge",  real'(done_k), real'(exp_done));
        check_val("done_count", real'(done_cnt), 1.0);
        check_val("toggle_seq", real'(tog_err), 0.0);
        check_val("busy_seq",   real'(busy_err), 0.0);
        check_val("voltage_avg", bus_if.voltage_avg, exp_avg[0]);
        check_val("current_avg", bus_if.current_avg, exp_avg[1]);
        check_val("power_avg",   bus_if.power_avg, exp_avg[2]);
        check_val("round_count", real'(bus_if.round_count), real'(exp_round));
    endtask

    initial begin
        rst                 = 1'b1;
        bus_if.start        = 1'b0;
        bus_if.channel_mask = 3'b000;
        bus_if.voltage_in   = 0.0;
        bus_if.current_in   = 0.0;
        bus_if.power_in     = 0.0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_idle_zero("reset");

        do_run(3'b111, 0, 0);
        check_val("const_vavg", bus_if.voltage_avg, 1.2);
        do_run(3'b001, 1, 0);
        check_val("step_vavg", bus_if.voltage_avg, 2.5);
        do_run(3'b000, 0, 0);
        do_run(3'b111, 2, 0);
        do_run(3'b111, 0, 20);
        do_run(3'b111, 0, 0);
        do_run(3'b101, 3, 0);
        for (int r = 0; r < 6; r++)
            do_run(3'($urandom_range(0, 7)), 4, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/analog_probe_sequencer.md
Name: analog_probe_sequencer

Overview:
- Initiator side of the analog probe toggle protocol.
- Issues voltage, current and power probe requests by flipping the probe's toggle lines.
- Waits a settle interval, then captures the returned real values and accumulates NUM_SAMPLES rounds.
- Presents per-channel averages with a done pulse. Sits in the mixed-signal testbench/digital wrapper beside the probe module, driven by the regulator control logic or cocotb.

Parameters:
- SETTLE_CYCLES, 2, clock edges between toggle flip and capture (legal 0..255).
- NUM_SAMPLES, 4, measurement rounds averaged per start (legal 1..65535).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a measurement run; sampled only in IDLE.
- channel_mask  input  3  bit0 voltage, bit1 current, bit2 power; latched on accepted start.
- probe_voltage_toggle  output  1  request line to probe voltage.
- probe_current_toggle  output  1  request line to probe current.
- probe_power_toggle  output  1  request line to probe power.
- voltage_in  input  real  probe voltage result.
- current_in  input  real  probe current result.
- power_in  input  real  probe power result.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse when averages are updated.
- voltage_avg  output  real  averaged voltage.
- current_avg  output  real  averaged current.
- power_avg  output  real  averaged power.
- round_count  output  16  completed rounds in the current run.

Behaviour:
- Reset values:
  - all toggles 0, busy 0, done 0, round_count 0.
  - all averages 0.0, accumulators 0.0, state IDLE.
- FSM states: IDLE, REQ, SETTLE, CAPTURE, FINISH.
- IDLE:
  - start=1 latches channel_mask, clears accumulators and round_count, sets busy=1.
  - Goes to REQ on the first enabled channel, in order voltage, current, power.
  - Mask 000 goes directly to FINISH.
- REQ:
  - Inverts the selected channel's toggle (single edge; no other toggle changes).
  - Loads settle counter; goes to SETTLE, or to CAPTURE if SETTLE_CYCLES=0.
- SETTLE: counts SETTLE_CYCLES edges, then goes to CAPTURE.
- CAPTURE:
  - Adds the selected *_in to that channel's accumulator.
  - Goes to REQ on the next enabled channel.
  - After the last enabled channel: round_count+1; then REQ on the first enabled channel, or FINISH if round_count reaches NUM_SAMPLES.
- Channel timing: each enabled channel conversion takes exactly SETTLE_CYCLES+2 edges.
- FINISH:
  - Each enabled channel's avg = accumulator / real'(NUM_SAMPLES).
  - Masked channels' avg are written 0.0.
  - done=1 for exactly this cycle; busy=0; returns to IDLE.
  - Averages hold until the next FINISH or rst.
- Latency: with K enabled channels and start accepted at edge E0, done is high after edge E0 + 1 + K*NUM_SAMPLES*(SETTLE_CYCLES+2).
- Mask 000: done after edge E0+1, all averages 0.0.
- start while busy: ignored, no effect on mask or run. start coincident with done cycle: ignored; start must be seen in IDLE.
- channel_mask changes during a run: no effect.
- Input values are sampled only in CAPTURE. Changes on *_in at other times are ignored.
- rst mid-run:
  - Next edge forces IDLE, toggles 0, busy 0, done 0.
  - Clears accumulators, averages and round_count.
  - A toggle returning 1→0 may trigger one extra probe evaluation; this is harmless and not captured.
- Averages use full real precision; no saturation. NaN/inf from the probe propagate unchanged.

Test Plan:
- Reset then idle 10 cycles → all toggles 0, busy 0, done 0, averages 0.0, round_count 0.
- Defaults, mask 111, inputs held at V=1.2, I=0.05, P=0.06, start at E0:
  - each toggle flips 4 times, voltage/current/power in rotation.
  - done exactly once after E49; averages 1.2/0.05/0.06; round_count 4.
- Mask 001, NUM_SAMPLES=4, voltage_in stepped to 1.0,2.0,3.0,4.0 before each CAPTURE:
  - voltage_avg 2.5, current_avg 0.0, power_avg 0.0.
  - only voltage toggle moves; done after E0+17.
- Mask 000 start → done after E0+1; toggles never move; all averages 0.0.
- start pulsed at E5 during a mask-111 run; mask changed to 010 mid-run → single done at E49; all three channels averaged.
- rst at E20 mid-run → next cycle IDLE, toggles 0, averages 0.0, no done. New start runs cleanly and completes after a further 49 edges.
